// File: rtl/input_buffer.sv
// ---------------------------------------------------------------------------
// input_buffer
//   Memory-mapped input peripheral: synchronizes board switches, synchronizes
//   and debounces push-buttons, and captures button press edges. Register
//   contents are returned on a combinational read port so a single-cycle core
//   can complete a load in the same cycle as the address is presented.
//
//   Register map, sel = {i_addr[28], i_addr[16:12]}:
//     6'b110000  SW    synchronized switches (RO)
//     6'b110001  BTN   debounced button levels, 1 = pressed (RO)
//     6'b110010  EDGE  press-capture bits (write-1-to-clear)
//     6'b110011  MASK  interrupt mask (RW, only with INPUT_BUFFER_IRQ_EN)
//
//   Optional feature macro: INPUT_BUFFER_IRQ_EN (adds MASK and o_irq).
//
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-low reset
//   i_wren     store strobe from LSU
//   i_addr     load/store address
//   i_data     store data
//   i_io_sw    raw switch levels (asynchronous to i_clk)
//   i_io_btn   raw buttons, active-low (0 = pressed)
//   o_rdata    read data, combinational from i_addr
//   o_hit      i_addr decodes to this block (combinational)
//   o_irq      registered |(EDGE & MASK)  [INPUT_BUFFER_IRQ_EN only]
// ---------------------------------------------------------------------------
module input_buffer #(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned DEBOUNCE_CNT = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wren,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_data,
  input  logic [31:0]        i_io_sw,
  input  logic [NUM_BTN-1:0] i_io_btn,
  output logic [31:0]        o_rdata,
`ifdef INPUT_BUFFER_IRQ_EN
  output logic               o_hit,
  output logic               o_irq
`else
  output logic               o_hit
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  localparam logic [5:0] SEL_SW   = 6'b110000;
  localparam logic [5:0] SEL_BTN  = 6'b110001;
  localparam logic [5:0] SEL_EDGE = 6'b110010;
`ifdef INPUT_BUFFER_IRQ_EN
  localparam logic [5:0] SEL_MASK = 6'b110011;
`endif

  // Address decode
  logic [5:0] w_sel;
  logic       w_edge_wr;

  assign w_sel     = {i_addr[28], i_addr[16:12]};
  assign o_hit     = i_addr[28] & i_addr[16];
  assign w_edge_wr = i_wren & (w_sel == SEL_EDGE);

  // Address/data bits this block never looks at
  logic w_unused;
  assign w_unused = &{1'b0, i_addr[31:29], i_addr[27:17], i_addr[11:0], i_data};

  // Switch two-flop synchronizer
  logic [31:0] r_sw_meta;
  logic [31:0] r_sw_sync;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_io_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Button synchronizer on raw active-low levels; reset to 1 = released.
  // Inverting after the flops is equivalent to inverting before them.
  logic [NUM_BTN-1:0] r_btn_meta;
  logic [NUM_BTN-1:0] r_btn_sync;
  logic [NUM_BTN-1:0] w_sb;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_btn_meta <= '1;
      r_btn_sync <= '1;
    end else begin
      r_btn_meta <= i_io_btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  assign w_sb = ~r_btn_sync;

  // Per-button debounce: accept a new level after DEBOUNCE_CNT consecutive
  // cycles of disagreement with the stable level
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_stable;
  logic [NUM_BTN-1:0] w_rise;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < int'(NUM_BTN); k++) begin
        r_cnt[k] <= '0;
      end
      r_stable <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_BTN); k++) begin
        if (w_sb[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_stable[k] <= w_sb[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // A press is accepted on the same edge that stable goes 0->1
  always_comb begin
    w_rise = '0;
    for (int k = 0; k < int'(NUM_BTN); k++) begin
      w_rise[k] = w_sb[k] & ~r_stable[k] & (r_cnt[k] == CNT_LAST);
    end
  end

  // Edge capture, write-1-to-clear; a same-cycle set overrides the clear
  logic [NUM_BTN-1:0] r_edge;
  logic [NUM_BTN-1:0] w_clr;

  assign w_clr = w_edge_wr ? i_data[NUM_BTN-1:0] : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_rise;
    end
  end

`ifdef INPUT_BUFFER_IRQ_EN
  // Interrupt mask and registered interrupt request
  logic [NUM_BTN-1:0] r_mask;
  logic               r_irq;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (i_wren && (w_sel == SEL_MASK)) begin
        r_mask <= i_data[NUM_BTN-1:0];
      end
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign o_irq = r_irq;
`endif

  // Combinational read mux
  always_comb begin
    o_rdata = '0;
    if (o_hit) begin
      case (w_sel)
        SEL_SW:   o_rdata = r_sw_sync;
        SEL_BTN:  o_rdata = 32'(r_stable);
        SEL_EDGE: o_rdata = 32'(r_edge);
`ifdef INPUT_BUFFER_IRQ_EN
        SEL_MASK: o_rdata = 32'(r_mask);
`endif
        default:  o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
module tb_input_buffer;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 4;

  localparam logic [31:0] A_SW   = 32'h1001_0000;
  localparam logic [31:0] A_BTN  = 32'h1001_1000;
  localparam logic [31:0] A_EDGE = 32'h1001_2000;
  localparam logic [31:0] A_MASK = 32'h1001_3000;
  localparam logic [31:0] A_MISS = 32'h1000_0000;
  localparam logic [31:0] SWV    = 32'hA5A5_0F0F;

  logic          clk;
  logic          rst_n;
  logic          wren;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic [31:0]   sw;
  logic [NB-1:0] btn;
  logic [31:0]   rdata;
  logic          hit;
`ifdef INPUT_BUFFER_IRQ_EN
  logic          irq;
`endif

  input_buffer #(.NUM_BTN(NB), .DEBOUNCE_CNT(DB)) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_wren   (wren),
    .i_addr   (addr),
    .i_data   (data),
    .i_io_sw  (sw),
    .i_io_btn (btn),
    .o_rdata  (rdata),
`ifdef INPUT_BUFFER_IRQ_EN
    .o_hit    (hit),
    .o_irq    (irq)
`else
    .o_hit    (hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string         name;
    logic [31:0]   sw;
    logic [NB-1:0] btn;
    int            cycles;
    logic [31:0]   addr;
    logic [31:0]   exp;
    logic          hit;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One active edge; inputs driven and outputs sampled 1ns after it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_hit);
    addr = a;
    #1;
    check(name, rdata, exp);
    check({name, "_hit"}, 32'(hit), 32'(exp_hit));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wren = 1'b1;
    addr = a;
    data = d;
    tick(1);
    wren = 1'b0;
    data = '0;
  endtask

  initial begin
    // name, sw, btn, cycles before read, read addr, expected rdata, expected hit
    tbl[0]  = '{"rst_sw",    32'h0, 4'hF, 0, A_SW,   32'h0, 1'b1};
    tbl[1]  = '{"rst_btn",   32'h0, 4'hF, 0, A_BTN,  32'h0, 1'b1};
    tbl[2]  = '{"rst_edge",  32'h0, 4'hF, 0, A_EDGE, 32'h0, 1'b1};
    tbl[3]  = '{"nohit",     32'h0, 4'hF, 0, A_MISS, 32'h0, 1'b0};
    tbl[4]  = '{"sw_e0",     SWV,   4'hF, 1, A_SW,   32'h0, 1'b1};
    tbl[5]  = '{"sw_e1",     SWV,   4'hF, 1, A_SW,   SWV,   1'b1};
    tbl[6]  = '{"btn0_e4",   SWV,   4'hE, 5, A_BTN,  32'h0, 1'b1};
    tbl[7]  = '{"btn0_e5",   SWV,   4'hE, 1, A_BTN,  32'h1, 1'b1};
    tbl[8]  = '{"edge0",     SWV,   4'hE, 0, A_EDGE, 32'h1, 1'b1};
    tbl[9]  = '{"glitch_in", SWV,   4'hC, 3, A_BTN,  32'h1, 1'b1};
    tbl[10] = '{"glitch_b",  SWV,   4'hE, 6, A_BTN,  32'h1, 1'b1};
    tbl[11] = '{"glitch_e",  SWV,   4'hE, 0, A_EDGE, 32'h1, 1'b1};
    tbl[12] = '{"edge01",    SWV,   4'hC, 6, A_EDGE, 32'h3, 1'b1};

    rst_n = 1'b0;
    wren  = 1'b0;
    addr  = '0;
    data  = '0;
    sw    = '0;
    btn   = '1;
    tick(3);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sw  = tbl[i].sw;
      btn = tbl[i].btn;
      tick(tbl[i].cycles);
      rd(tbl[i].name, tbl[i].addr, tbl[i].exp, tbl[i].hit);
    end

    // W1C clears only the written bit
    store(A_EDGE, 32'h1);
    rd("w1c_bit0", A_EDGE, 32'h2, 1'b1);

    // Release btn1, clear everything, then collide a clear with a re-press
    btn = 4'hE;
    tick(6);
    rd("rel_btn1", A_BTN, 32'h1, 1'b1);
    store(A_EDGE, 32'hF);
    rd("w1c_all", A_EDGE, 32'h0, 1'b1);
    btn = 4'hC;
    tick(5);
    rd("pre_coll", A_EDGE, 32'h0, 1'b1);
    store(A_EDGE, 32'h2);
    rd("coll_edge", A_EDGE, 32'h2, 1'b1);
    rd("coll_btn", A_BTN, 32'h3, 1'b1);

    // Stores to read-only / unmapped / non-hit addresses change nothing
    store(A_SW, 32'hFFFF_FFFF);
    rd("ro_sw", A_SW, SWV, 1'b1);
    store(A_BTN, 32'hFFFF_FFFF);
    rd("ro_btn", A_BTN, 32'h3, 1'b1);
    store(32'h1000_2000, 32'hFFFF_FFFF);
    rd("miss_st", A_EDGE, 32'h2, 1'b1);
    rd("lsb_ign", A_EDGE | 32'h0000_0FFC, 32'h2, 1'b1);

`ifdef INPUT_BUFFER_IRQ_EN
    store(A_MASK, 32'h4);
    rd("mask_rd", A_MASK, 32'h4, 1'b1);
    check("irq_idle", 32'(irq), 32'h0);
    btn = 4'h8;
    tick(6);
    rd("edge2", A_EDGE, 32'h6, 1'b1);
    check("irq_same", 32'(irq), 32'h0);
    tick(1);
    check("irq_set", 32'(irq), 32'h1);
    store(A_EDGE, 32'h4);
    check("irq_hold", 32'(irq), 32'h1);
    tick(1);
    check("irq_clr", 32'(irq), 32'h0);
    store(A_MASK, 32'h0);
    store(A_EDGE, 32'hF);
    btn = 4'h9;
    tick(6);
    btn = 4'h8;
    tick(6);
    rd("edge_b0", A_EDGE, 32'h1, 1'b1);
    tick(2);
    check("irq_masked", 32'(irq), 32'h0);
`else
    store(A_MASK, 32'hF);
    rd("mask_unmap", A_MASK, 32'h0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
